// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster counters, registered syncs, display enable and frame counter
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int FC_W      = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  output logic [9:0]      pix_x,
  output logic [9:0]      pix_y,
  output logic            hsync,
  output logic            vsync,
  output logic            display_on,
  output logic            frame_end,
  output logic [FC_W-1:0] frame_count
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  logic [9:0] nx, ny;
  logic h_end, v_end;
  always_comb begin
    h_end = pix_x == 10'(H_TOTAL - 1);
    v_end = pix_y == 10'(V_TOTAL - 1);
    nx = h_end ? '0 : pix_x + 10'd1;
    ny = h_end ? (v_end ? '0 : pix_y + 10'd1) : pix_y;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pix_x       <= '0;
      pix_y       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      display_on  <= 1'b1;
      frame_end   <= 1'b0;
      frame_count <= '0;
    end else if (en) begin
      pix_x       <= nx;
      pix_y       <= ny;
      hsync       <= !(nx >= 10'(H_DISPLAY + H_FRONT) && nx < 10'(H_DISPLAY + H_FRONT + H_SYNC));
      vsync       <= !(ny >= 10'(V_DISPLAY + V_FRONT) && ny < 10'(V_DISPLAY + V_FRONT + V_SYNC));
      display_on  <= nx < 10'(H_DISPLAY) && ny < 10'(V_DISPLAY);
      frame_end   <= nx == 10'(H_TOTAL - 1) && ny == 10'(V_TOTAL - 1);
      frame_count <= (h_end && v_end) ? frame_count + FC_W'(1) : frame_count;
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: full-size, mid-size and tiny instances checked against a position-count model
module tb_vga_timing_gen;
  logic clk = 0, reset = 0, en = 1;
  always #5 clk = ~clk;
  logic [9:0] fx, fy, mx, my, sx, sy;
  logic fhs, fvs, fde, ffe, mhs, mvs, mde, mfe, shs, svs, sde, sfe;
  logic [7:0] ffc, mfc, sfc;
  int errors = 0, checks = 0, n = 0;
  vga_timing_gen f (.clk(clk), .reset(reset), .en(en), .pix_x(fx), .pix_y(fy), .hsync(fhs), .vsync(fvs),
    .display_on(fde), .frame_end(ffe), .frame_count(ffc));
  vga_timing_gen #(.H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4), .V_DISPLAY(48), .V_FRONT(2),
    .V_SYNC(2), .V_BACK(3)) m (.clk(clk), .reset(reset), .en(en), .pix_x(mx), .pix_y(my), .hsync(mhs),
    .vsync(mvs), .display_on(mde), .frame_end(mfe), .frame_count(mfc));
  vga_timing_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .V_DISPLAY(4), .V_FRONT(1),
    .V_SYNC(1), .V_BACK(1)) s (.clk(clk), .reset(reset), .en(en), .pix_x(sx), .pix_y(sy), .hsync(shs),
    .vsync(svs), .display_on(sde), .frame_end(sfe), .frame_count(sfc));
  // every output is a pure function of how many enabled edges have elapsed since reset
  always @(posedge clk or posedge reset)
    if (reset) n <= 0;
    else if (en) n <= n + 1;
  function automatic logic [31:0] exp_out(int k, int hd, int hf, int hs, int hb, int vd, int vf, int vs, int vb);
    int ht = hd + hf + hs + hb;
    int vt = vd + vf + vs + vb;
    int x = k % ht;
    int y = (k / ht) % vt;
    int fr = (k / (ht * vt)) % 256;
    return {x[9:0], y[9:0], !(x >= hd + hf && x < hd + hf + hs), !(y >= vd + vf && y < vd + vf + vs),
            x < hd && y < vd, x == ht - 1 && y == vt - 1, fr[7:0]};
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("full", {fx, fy, fhs, fvs, fde, ffe, ffc}, exp_out(n, 640, 16, 96, 48, 480, 10, 2, 33));
    chk("mid", {mx, my, mhs, mvs, mde, mfe, mfc}, exp_out(n, 64, 4, 8, 4, 48, 2, 2, 3));
    chk("small", {sx, sy, shs, svs, sde, sfe, sfc}, exp_out(n, 8, 2, 2, 2, 4, 1, 1, 1));
  end
  int m_tot = 0, m_de = 0, m_vs = 0, m_hs = 0, m_fe = 0, h_cnt = 0, h_first = -1;
  always @(posedge clk)
    if (en && !reset) begin
      if (mfc == 8'd1) begin
        m_tot <= m_tot + 1;
        m_de <= m_de + int'(mde);
        m_vs <= m_vs + int'(!mvs);
        m_hs <= m_hs + int'(!mhs);
        m_fe <= m_fe + int'(mfe);
      end
      if (fy == 0 && ffc == 0 && !fhs) begin
        if (h_cnt == 0) h_first <= int'(fx);
        h_cnt <= h_cnt + 1;
      end
    end
  logic [7:0] prev_sfc = 0;
  logic wrap_seen = 0;
  always @(negedge clk) begin
    if (prev_sfc == 8'd255 && sfc != 8'd255) begin
      chk("fc_wrap", 32'(sfc), 32'd0);
      wrap_seen = 1;
    end
    prev_sfc = sfc;
  end
  task automatic timeout(string nm, logic ok);
    chk(nm, 32'(ok), 32'd1);
  endtask
  initial begin
    #1 reset = 1;
    #2 chk("rst_full", {fx, fy, fhs, fvs, fde, ffe, ffc}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
    repeat (3) @(posedge clk);
    #2 reset = 0;
    @(posedge clk);
    #1 chk("first_x", {22'd0, fx}, 32'd1);
    for (int i = 0; i < 2000 && fx != 10'd100; i++) begin @(posedge clk); #2; end
    timeout("wait_x100", fx == 10'd100);
    en = 0;
    repeat (5) @(posedge clk);
    #2 en = 1;
    for (int i = 0; i < 20000 && !(mx == 10'd79 && my == 10'd54 && mfc == 8'd1); i++) begin @(posedge clk); #2; end
    timeout("wait_mid_end", mx == 10'd79 && my == 10'd54 && mfc == 8'd1);
    en = 0;
    repeat (5) begin
      @(posedge clk);
      #1 chk("fe_hold", 32'(mfe), 32'd1);
    end
    #1 en = 1;
    for (int i = 0; i < 6000 && mfc != 8'd2; i++) begin @(posedge clk); #2; end
    timeout("wait_mid_f2", mfc == 8'd2);
    chk("mid_total", m_tot, 4400);
    chk("mid_de", m_de, 64 * 48);
    chk("mid_vs_low", m_vs, 2 * 80);
    chk("mid_hs_low", m_hs, 8 * 55);
    chk("mid_fe", m_fe, 1);
    chk("full_hs_cnt", h_cnt, 96);
    chk("full_hs_first", h_first, 656);
    for (int i = 0; i < 30000 && !wrap_seen; i++) @(posedge clk);
    timeout("wait_wrap", wrap_seen);
    for (int i = 0; i < 2000 && fx != 10'd300; i++) begin @(posedge clk); #2; end
    timeout("wait_x300", fx == 10'd300);
    @(negedge clk);
    #2 reset = 1;
    #1 chk("async_full", {fx, fy, fhs, fvs, fde, ffe, ffc}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
    chk("async_mid", {mx, my, mhs, mvs, mde, mfe, mfc}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
    @(posedge clk);
    #2 reset = 0;
    @(posedge clk);
    #1 chk("post_rst", {4'd0, fx, fy, ffc}, {4'd0, 10'd1, 10'd0, 8'd0});
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
